// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: fetch-time tag/target/counter lookup, trained by execute.
// Define BP_PERF_CNT_EN to implement the branch and mispredict performance counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_pc_f,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_pc,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0] ctr_q    [ENTRIES];

  logic [IDX_W-1:0] fetchIdx;
  logic [TAG_W-1:0] fetchTag;
  logic             fetchHit;
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic             effTaken;
  logic [XLEN-1:0]  correctPc;

  logic             entryWe;
  logic             tagWe;
  logic             valid_d;
  logic [CTR_W-1:0] ctr_d;

  // Low PC bits and the piped direction guess carry no information for this table.
  logic unusedBits;
  assign unusedBits = ^{pc_f[1:0], upd_pc[1:0], upd_pred_taken};

  assign fetchIdx     = pc_f[IDX_W+1:2];
  assign fetchTag     = pc_f[XLEN-1:IDX_W+2];
  assign fetchHit     = valid_q[fetchIdx] && (tag_q[fetchIdx] == fetchTag);
  assign pred_taken_f = fetchHit && ctr_q[fetchIdx][CTR_W-1];
  assign pred_pc_f    = pred_taken_f ? target_q[fetchIdx] : pc_f + XLEN'(4);

  assign updIdx = upd_pc[IDX_W+1:2];
  assign updTag = upd_pc[XLEN-1:IDX_W+2];
  assign updHit = valid_q[updIdx] && (tag_q[updIdx] == updTag);

  assign effTaken    = upd_is_jump | (upd_is_branch & upd_taken);
  assign correctPc   = effTaken ? upd_target : upd_pc + XLEN'(4);
  assign mispredict  = upd_valid && (upd_pred_pc != correctPc);
  assign redirect_pc = correctPc;

  // Jump beats branch; a hitting non-control instruction is an alias and drops its entry.
  always_comb begin
    entryWe = 1'b0;
    tagWe   = 1'b0;
    valid_d = valid_q[updIdx];
    ctr_d   = ctr_q[updIdx];
    if (upd_valid) begin
      if (upd_is_jump) begin
        entryWe = 1'b1;
        tagWe   = 1'b1;
        valid_d = 1'b1;
        ctr_d   = CTR_MAX;
      end else if (upd_is_branch) begin
        if (updHit) begin
          entryWe = 1'b1;
          tagWe   = 1'b1;
          if (upd_taken) begin
            if (ctr_q[updIdx] != CTR_MAX) ctr_d = ctr_q[updIdx] + CTR_W'(1);
          end else begin
            if (ctr_q[updIdx] != '0) ctr_d = ctr_q[updIdx] - CTR_W'(1);
          end
        end else if (upd_taken) begin
          entryWe = 1'b1;
          tagWe   = 1'b1;
          valid_d = 1'b1;
          ctr_d   = CTR_WEAK;
        end
      end else if (updHit) begin
        entryWe = 1'b1;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= '0;
      end
    end else if (entryWe) begin
      valid_q[updIdx] <= valid_d;
      ctr_q[updIdx]   <= ctr_d;
    end
  end

  // Tag and target are only meaningful behind a valid bit, so they skip reset.
  always_ff @(posedge clk) begin
    if (tagWe) begin
      tag_q[updIdx]    <= updTag;
      target_q[updIdx] <= upd_target;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branchCount_q;
  logic [31:0] mispredictCount_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branchCount_q     <= '0;
      mispredictCount_q <= '0;
    end else begin
      if (upd_valid && (upd_is_branch || upd_is_jump)) branchCount_q <= branchCount_q + 32'd1;
      if (mispredict) mispredictCount_q <= mispredictCount_q + 32'd1;
    end
  end

  assign branch_count     = branchCount_q;
  assign mispredict_count = mispredictCount_q;
`else
  assign branch_count     = '0;
  assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table model predicts each cycle's outputs,
// expectations go through a scoreboard queue and are compared at the falling edge.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_pc;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_W(2)) dut (
    .clk(clk), .reset(reset), .pc_f(pc_f), .pred_taken_f(pred_taken_f), .pred_pc_f(pred_pc_f),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_pc(upd_pred_pc), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        predTaken;
    logic [31:0] predPc;
    logic        mis;
    logic [31:0] redirect;
    logic [31:0] branchCnt;
    logic [31:0] misCnt;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];
  int    checkCount = 0;
  int    errorCount = 0;

  // Reference table, 16 entries: index pc[5:2], tag pc[31:6].
  logic        mValid  [16];
  logic [25:0] mTag    [16];
  logic [31:0] mTarget [16];
  logic [1:0]  mCtr    [16];
  logic [31:0] mBranchCnt;
  logic [31:0] mMisCnt;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic mHit(input logic [31:0] pc);
    return mValid[pc[5:2]] && (mTag[pc[5:2]] == pc[31:6]);
  endfunction

  function automatic logic mPredTaken(input logic [31:0] pc);
    return mHit(pc) && mCtr[pc[5:2]][1];
  endfunction

  function automatic logic [31:0] mPredPc(input logic [31:0] pc);
    return mPredTaken(pc) ? mTarget[pc[5:2]] : pc + 32'd4;
  endfunction

  function automatic logic [31:0] cntView(input logic [31:0] c);
`ifdef BP_PERF_CNT_EN
    return c;
`else
    return (c & 32'h0);
`endif
  endfunction

  task automatic mReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 2'd0;
    end
    mBranchCnt = 32'd0;
    mMisCnt    = 32'd0;
  endtask

  task automatic mUpdate();
    logic [31:0] correct;
    logic [3:0]  i;
    logic        hit;
    if (!upd_valid) return;
    i       = upd_pc[5:2];
    hit     = mHit(upd_pc);
    correct = (upd_is_jump || (upd_is_branch && upd_taken)) ? upd_target : upd_pc + 32'd4;
    if (upd_pred_pc != correct) mMisCnt++;
    if (upd_is_branch || upd_is_jump) mBranchCnt++;
    if (upd_is_jump) begin
      mValid[i] = 1'b1; mTag[i] = upd_pc[31:6]; mTarget[i] = upd_target; mCtr[i] = 2'd3;
    end else if (upd_is_branch) begin
      if (hit) begin
        mTarget[i] = upd_target;
        if (upd_taken) mCtr[i] = (mCtr[i] == 2'd3) ? 2'd3 : mCtr[i] + 2'd1;
        else           mCtr[i] = (mCtr[i] == 2'd0) ? 2'd0 : mCtr[i] - 2'd1;
      end else if (upd_taken) begin
        mValid[i] = 1'b1; mTag[i] = upd_pc[31:6]; mTarget[i] = upd_target; mCtr[i] = 2'd2;
      end
    end else if (hit) begin
      mValid[i] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] pcF, input logic uv,
                               input logic [31:0] upc, input logic br, input logic j,
                               input logic tk, input logic [31:0] tgt, input logic corrupt);
    exp_t        e;
    logic [31:0] correct;
    pc_f           = pcF;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_is_branch  = br;
    upd_is_jump    = j;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_taken = mPredTaken(upc);
    upd_pred_pc    = mPredPc(upc) ^ (corrupt ? 32'h10 : 32'h0);
    correct        = (j || (br && tk)) ? tgt : upc + 32'd4;
    e.predTaken    = mPredTaken(pcF);
    e.predPc       = mPredPc(pcF);
    e.mis          = uv && (upd_pred_pc != correct);
    e.redirect     = correct;
    e.branchCnt    = cntView(mBranchCnt);
    e.misCnt       = cntView(mMisCnt);
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic compareScoreboard();
    exp_t  e;
    string t;
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 32'd1, 32'd0);
      return;
    end
    e = expQ.pop_front();
    t = tagQ.pop_front();
    checkOutput({t, ".predTaken"}, {31'd0, pred_taken_f}, {31'd0, e.predTaken});
    checkOutput({t, ".predPc"}, pred_pc_f, e.predPc);
    checkOutput({t, ".mispredict"}, {31'd0, mispredict}, {31'd0, e.mis});
    if (e.mis) checkOutput({t, ".redirect"}, redirect_pc, e.redirect);
    checkOutput({t, ".branchCount"}, branch_count, e.branchCnt);
    checkOutput({t, ".mispredictCount"}, mispredict_count, e.misCnt);
  endtask

  // One pipeline cycle: drive after the rising edge, compare at the falling edge, train the model.
  task automatic runCycle(input string tag, input logic [31:0] pcF, input logic uv,
                          input logic [31:0] upc, input logic br, input logic j,
                          input logic tk, input logic [31:0] tgt, input logic corrupt);
    applyStimulus(tag, pcF, uv, upc, br, j, tk, tgt, corrupt);
    @(negedge clk);
    compareScoreboard();
    @(posedge clk);
    mUpdate();
    #1;
  endtask

  initial begin
    logic [31:0] rPc, rUpc, rTgt;
    int          kind;
    reset = 1'b1;
    pc_f = 32'h40; upd_valid = 1'b0; upd_pc = 32'h0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_pc = 32'h0;
    mReset();
    #12;
    checkOutput("resetPredTaken", {31'd0, pred_taken_f}, 32'd0);
    checkOutput("resetPredPc", pred_pc_f, 32'h44);
    checkOutput("resetBranchCount", branch_count, 32'd0);
    checkOutput("resetMispredictCount", mispredict_count, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    runCycle("addNoMis",     32'h40, 1, 32'h40, 0, 0, 0, 32'h0, 0);
    runCycle("brFirstTaken", 32'h40, 1, 32'h40, 1, 0, 1, 32'h80, 0);
    runCycle("brNowTaken",   32'h40, 0, 32'h0,  0, 0, 0, 32'h0, 0);
    runCycle("brNt1",        32'h40, 1, 32'h40, 1, 0, 0, 32'h80, 0);
    runCycle("brNt2",        32'h40, 1, 32'h40, 1, 0, 0, 32'h80, 0);
    for (int i = 0; i < 4; i++)
      runCycle($sformatf("brTk%0d", i), 32'h40, 1, 32'h40, 1, 0, 1, 32'h80, 0);
    runCycle("brSat",        32'h40, 1, 32'h40, 1, 0, 0, 32'h80, 0);
    runCycle("brSatCheck",   32'h40, 0, 32'h0,  0, 0, 0, 32'h0, 0);
    runCycle("jalAlloc",     32'h100, 1, 32'h100, 0, 1, 1, 32'h20, 0);
    runCycle("addOtherTag",  32'h100, 1, 32'h140, 0, 0, 0, 32'h0, 0);
    runCycle("aliasAdd",     32'h100, 1, 32'h100, 0, 0, 0, 32'h0, 0);
    runCycle("aliasGone",    32'h100, 0, 32'h0,   0, 0, 0, 32'h0, 0);
    runCycle("pcWrap",       32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h8, 0);

    for (int n = 0; n < 300; n++) begin
      rPc  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      rUpc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      rTgt = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      kind = $urandom_range(0, 3);
      runCycle($sformatf("rand%0d", n), rPc, (kind != 0), rUpc, (kind == 1), (kind == 2),
               1'($urandom_range(0, 1)), rTgt, ($urandom_range(0, 7) == 0));
    end

    runCycle("jalPreReset",  32'h180, 1, 32'h180, 0, 1, 1, 32'h500, 0);
    applyStimulus("preReset", 32'h180, 0, 32'h0, 0, 0, 0, 32'h0, 0);
    @(negedge clk);
    compareScoreboard();
    #2 reset = 1'b1;
    #1;
    checkOutput("midResetPredTaken", {31'd0, pred_taken_f}, 32'd0);
    checkOutput("midResetPredPc", pred_pc_f, 32'h184);
    checkOutput("midResetBranchCount", branch_count, 32'd0);
    checkOutput("midResetMispredictCount", mispredict_count, 32'd0);
    mReset();
    @(posedge clk);
    #2 reset = 1'b0;

    runCycle("perfBr1", 32'h200, 1, 32'h200, 1, 0, 1, 32'h300, 0);
    runCycle("perfBr2", 32'h200, 1, 32'h200, 1, 0, 1, 32'h300, 0);
    runCycle("perfBr3", 32'h204, 1, 32'h204, 1, 0, 0, 32'h300, 0);
    runCycle("perfBr4", 32'h208, 1, 32'h208, 1, 0, 0, 32'h300, 0);
    runCycle("perfJal", 32'h20C, 1, 32'h20C, 0, 1, 1, 32'h400, 0);
`ifdef BP_PERF_CNT_EN
    checkOutput("perfBranchTotal", branch_count, 32'd5);
    checkOutput("perfMispredictTotal", mispredict_count, 32'd2);
`else
    checkOutput("perfBranchTotal", branch_count, 32'd0);
    checkOutput("perfMispredictTotal", mispredict_count, 32'd0);
`endif
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
